clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_pkg.sv | 30 +++
 rtl/clk_gate_idle_cnt.sv | 58 +++++
 rtl/clk_gate_ctrl.sv | 157 +++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// ---------------------------------------------------------------------------
// clk_gate_pkg
//   Shared definitions for the clock-gate controller:
//     - cg_state_e    : FSM state encoding, visible on CG_STATE
//     - IDLE_W_DEF    : default width of the idle-timeout limit and counter
//     - WAKE_CYC_DEF  : default number of CLK_EN-high cycles before ACK
//     - WAKE_W        : width of the wake counter (WAKE_CYC legal in 1..15)
//     - wake_load()   : value loaded into the wake counter on leaving OFF
// ---------------------------------------------------------------------------
package clk_gate_pkg;

    localparam int IDLE_W_DEF   = 4;
    localparam int WAKE_CYC_DEF = 2;
    localparam int WAKE_W       = 4;

    // Encodings are part of the external interface (CG_STATE).
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } cg_state_e;

    // The wake counter counts down to zero, so it starts at WAKE_CYC-1:
    // the edge that reads zero is the WAKE_CYC-th edge after entering WAKE.
    function automatic logic [WAKE_W-1:0] wake_load(input int wake_cyc);
        return WAKE_W'(wake_cyc - 1);
    endfunction

endpackage : clk_gate_pkg

// File: rtl/clk_gate_idle_cnt.sv
// ---------------------------------------------------------------------------
// clk_gate_idle_cnt
//   Saturating idle counter with compare-to-limit, used while the controller
//   sits in HOLD waiting to gate the clock off.
//
//   Ports
//     clk       in   free-running clock
//     rst       in   asynchronous, active-high reset (counter -> 0)
//     clear     in   force the counter to zero on the next edge (priority)
//     inc       in   count this cycle; also qualifies the limit compare
//     limit     in   [IDLE_W] idle cycles tolerated before timeout
//     at_limit  out  counter equals limit-1 while inc is high
// ---------------------------------------------------------------------------
module clk_gate_idle_cnt
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W = IDLE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    input  logic [IDLE_W-1:0] limit,
    output logic              at_limit
);

    localparam logic [IDLE_W-1:0] CNT_MAX = {IDLE_W{1'b1}};

    logic [IDLE_W-1:0] cnt_q;
    logic [IDLE_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every combinationally assigned variable gets a default first,
        // so no path through the block leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            // Saturate at all-ones instead of wrapping back to zero.
            cnt_d = cnt_q + IDLE_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and every
    // flop (counters included) has an explicit reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The limit is only looked at while counting (inc = in HOLD), so
    // IDLE_LIMIT changes elsewhere cannot influence a timeout.
    assign at_limit = inc && (cnt_q == (limit - IDLE_W'(1)));

endmodule : clk_gate_idle_cnt

// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//   Request/acknowledge controller for a latch-based clock-gating cell.
//   OFF -> WAKE (fixed settle time) -> ON (granted) -> HOLD (idle grace
//   period) -> OFF. CLK_EN and ACK are both dedicated flops so the gating
//   cell enable never sees decode glitches and changes at most once per CLK.
//
//   Parameters
//     IDLE_W      width of IDLE_LIMIT and the idle counter
//     WAKE_CYC    cycles CLK_EN is high before ACK may assert (1..15)
//
//   Ports
//     CLK         in   free-running clock for all state
//     RST         in   asynchronous, active-high reset
//     REQ         in   consumer requests its gated clock (level)
//     BUSY        in   consumer still active; prevents entering HOLD
//     FORCE_ON    in   debug override: wake and stay on, no timeout
//     IDLE_LIMIT  in   [IDLE_W] idle cycles tolerated in HOLD (quasi-static)
//     CLK_EN      out  enable to the clock-gating cell (registered)
//     ACK         out  gated clock stable and REQ granted (registered)
//     CG_STATE    out  [2] current state: OFF=0 WAKE=1 ON=2 HOLD=3
// ---------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic [IDLE_W-1:0] IDLE_LIMIT,
    output logic              CLK_EN,
    output logic              ACK,
    output logic [1:0]        CG_STATE
);

    localparam logic [WAKE_W-1:0] WAKE_LOAD = wake_load(WAKE_CYC);

    cg_state_e         state_q;
    cg_state_e         state_d;
    logic [WAKE_W-1:0] wake_cnt_q;
    logic [WAKE_W-1:0] wake_cnt_d;
    logic              clk_en_q;
    logic              clk_en_d;
    logic              ack_q;
    logic              ack_d;

    logic              wake_req;      // reason to leave OFF
    logic              keep_on;       // reason to stay in / return to ON
    logic              idle_inc;
    logic              idle_clear;
    logic              idle_timeout;

    assign wake_req = REQ | FORCE_ON;
    assign keep_on  = REQ | BUSY | FORCE_ON;

    // Kept outside the output process: the next-state logic depends on the
    // timeout, which must not appear to depend on state_d.
    assign idle_inc = (state_q == ST_HOLD);

    clk_gate_idle_cnt #(
        .IDLE_W   (IDLE_W)
    ) u_idle_cnt (
        .clk      (CLK),
        .rst      (RST),
        .clear    (idle_clear),
        .inc      (idle_inc),
        .limit    (IDLE_LIMIT),
        .at_limit (idle_timeout)
    );

    // -----------------------------------------------------------------------
    // State register (plus the registered outputs and wake counter)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_OFF;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= clk_en_d;
            ack_q      <= ack_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (wake_req) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                // A dropped REQ does not abort the wake; ON is always reached.
                if (wake_cnt_q == '0) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!keep_on) begin
                    // A zero limit means "no grace period": gate off directly.
                    state_d = (IDLE_LIMIT != '0) ? ST_HOLD : ST_OFF;
                end
            end
            ST_HOLD: begin
                // Renewed activity wins over a timeout on the same edge.
                if (keep_on) begin
                    state_d = ST_ON;
                end else if (idle_timeout) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath logic (next values of the registered outputs)
    // -----------------------------------------------------------------------
    always_comb begin
        // The enable follows the next state, so it rises on the edge that
        // leaves OFF and falls on the edge that enters OFF.
        clk_en_d = (state_d != ST_OFF);

        // ACK is REQ registered, but only once ON is (being) reached; this
        // also gives ACK=0 in WAKE and HOLD and on a REQ-less wake.
        ack_d = (state_d == ST_ON) && REQ;

        wake_cnt_d = '0;
        if ((state_q == ST_OFF) && (state_d == ST_WAKE)) begin
            wake_cnt_d = WAKE_LOAD;
        end else if ((state_q == ST_WAKE) && (wake_cnt_q != '0)) begin
            wake_cnt_d = wake_cnt_q - WAKE_W'(1);
        end

        // Held at zero outside HOLD, so each HOLD visit starts from zero.
        idle_clear = (state_d != ST_HOLD);
    end

    // CLK_EN drives the gating-cell enable directly from its flop.
    assign CLK_EN   = clk_en_q;
    assign ACK      = ack_q;
    assign CG_STATE = state_q;

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
//   Self-checking bench for clk_gate_ctrl (IDLE_W=4, WAKE_CYC=2).
//   Each scenario task lists per-cycle stimulus together with the expected
//   outputs after the following rising edge; expectations are queued when
//   the stimulus is driven and popped/compared after the edge.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;

    localparam int IW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ = 1'b0;
    logic          BUSY = 1'b0;
    logic          FORCE_ON = 1'b0;
    logic [IW-1:0] IDLE_LIMIT = IW'(8);
    logic          CLK_EN;
    logic          ACK;
    logic [1:0]    CG_STATE;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic          rst;
        logic          req;
        logic          busy;
        logic          frc;
        logic [IW-1:0] lim;
        logic          en;
        logic          ack;
        logic [1:0]    st;
    } step_t;

    typedef struct {
        string      tag;
        logic       en;
        logic       ack;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    clk_gate_ctrl #(
        .IDLE_W     (IW),
        .WAKE_CYC   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .BUSY       (BUSY),
        .FORCE_ON   (FORCE_ON),
        .IDLE_LIMIT (IDLE_LIMIT),
        .CLK_EN     (CLK_EN),
        .ACK        (ACK),
        .CG_STATE   (CG_STATE)
    );

    always #5 CLK = ~CLK;

    // ACK must never be high without the clock enabled.
    always @(negedge CLK) begin
        checks_total++;
        if (ACK === 1'b1 && CLK_EN !== 1'b1)
            $display("FAIL ack_implies_en @%0t: ack=%b clk_en=%b, required clk_en=1", $time, ACK, CLK_EN);
        else
            checks_passed++;
    end

    function automatic step_t mk(input logic rst, input logic req, input logic busy,
                                 input logic frc, input logic [IW-1:0] lim,
                                 input logic en, input logic ack, input logic [1:0] st);
        step_t s;
        s.rst = rst; s.req = req; s.busy = busy; s.frc = frc; s.lim = lim;
        s.en = en; s.ack = ack; s.st = st;
        return s;
    endfunction

    function automatic exp_t exp_of(input string tag, input step_t s);
        exp_t e;
        e.tag = tag; e.en = s.en; e.ack = s.ack; e.st = s.st;
        return e;
    endfunction

    task automatic apply(input step_t s);
        RST        = s.rst;
        REQ        = s.req;
        BUSY       = s.busy;
        FORCE_ON   = s.frc;
        IDLE_LIMIT = s.lim;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        step_t q[$];
        exp_t  e;
        // Async reset before any clock edge.
        RST = 1'b0;
        #1 RST = 1'b1;
        #2;
        sb.push_back('{"reset_async", 1'b0, 1'b0, 2'd0});
        e = sb.pop_front();
        checks_total++;
        if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
            $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
        else
            checks_passed++;
        // REQ is ignored under reset; after release nothing wakes without REQ.
        q.push_back(mk(1, 1, 0, 0, 8, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 0, 8, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("reset[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // From OFF: REQ sampled at edge 0 -> WAKE, WAKE, ON with ACK at edge 2.
    task automatic test_basic_wake();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("basic_wake[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // From ON, IDLE_LIMIT=8: eight cycles in HOLD, then gated off.
    task automatic test_idle_timeout();
        step_t q[$];
        exp_t  e;
        for (int k = 0; k < 8; k++) q.push_back(mk(0, 0, 0, 0, 8, 1, 0, 3));
        q.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("idle_timeout[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Re-request at idle count 5 returns to ON with ACK; CLK_EN stays high.
    task automatic test_rerequest();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
        for (int k = 0; k < 6; k++) q.push_back(mk(0, 0, 0, 0, 8, 1, 0, 3));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
        q.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("rerequest[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // BUSY hold, IDLE_LIMIT=0, REQ coinciding with timeout, REQ dropped in
    // WAKE, IDLE_LIMIT=1. Starts in ON with REQ=1.
    task automatic test_boundaries();
        step_t q[$];
        exp_t  e;
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 1, 0, 0, 1, 0, 2));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // Timeout edge (count 1 with limit 2) coincides with REQ.
        q.push_back(mk(0, 1, 0, 0, 2, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 2, 1, 0, 1));
        q.push_back(mk(0, 1, 0, 0, 2, 1, 1, 2));
        q.push_back(mk(0, 0, 0, 0, 2, 1, 0, 3));
        q.push_back(mk(0, 0, 0, 0, 2, 1, 0, 3));
        q.push_back(mk(0, 1, 0, 0, 2, 1, 1, 2));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // REQ drops during WAKE: ON still reached, without ACK.
        q.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2));
        q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3));
        q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("boundaries[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // FORCE_ON without REQ: wake to ON and stay 100 cycles with ACK=0, then
    // release into HOLD.
    task automatic test_force_on();
        step_t q[$];
        exp_t  e;
        q.push_back(mk(0, 0, 0, 1, 8, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 1, 8, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 1, 8, 1, 0, 2));
        for (int k = 0; k < 100; k++) q.push_back(mk(0, 0, 0, 1, 8, 1, 0, 2));
        q.push_back(mk(0, 0, 0, 0, 8, 1, 0, 3));
        foreach (q[i]) begin
            apply(q[i]);
            sb.push_back(exp_of($sformatf("force_on[%0d]", i), q[i]));
            tick();
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // RST asserted between edges in HOLD, ON (ACK=1) and WAKE; outputs must
    // clear before the next edge and a fresh wake must take the full latency.
    task automatic test_async_reset();
        string names[3] = '{"mid_hold", "mid_on", "mid_wake"};
        for (int ph = 0; ph < 3; ph++) begin
            step_t pre[$];
            step_t post[$];
            exp_t  e;
            case (ph)
                0: begin
                    pre.push_back(mk(0, 0, 0, 0, 8, 1, 0, 3));
                    pre.push_back(mk(0, 0, 0, 0, 8, 1, 0, 3));
                    post.push_back(mk(1, 0, 0, 0, 8, 0, 0, 0));
                    post.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
                    post.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
                end
                1: begin
                    pre.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
                    pre.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
                    pre.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
                    pre.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
                    post.push_back(mk(1, 1, 0, 0, 8, 0, 0, 0));
                    post.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
                    post.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
                    post.push_back(mk(0, 1, 0, 0, 8, 1, 1, 2));
                    post.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
                end
                default: begin
                    pre.push_back(mk(0, 1, 0, 0, 8, 1, 0, 1));
                    post.push_back(mk(1, 0, 0, 0, 8, 0, 0, 0));
                    post.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
                    post.push_back(mk(0, 0, 0, 0, 8, 0, 0, 0));
                end
            endcase
            foreach (pre[i]) begin
                apply(pre[i]);
                sb.push_back(exp_of($sformatf("%s_pre[%0d]", names[ph], i), pre[i]));
                tick();
                e = sb.pop_front();
                checks_total++;
                if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                    $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
                else
                    checks_passed++;
            end
            // Mid-cycle: assert reset 3 ns after the edge, check 1 ns later.
            #2 RST = 1'b1;
            sb.push_back('{$sformatf("%s_async", names[ph]), 1'b0, 1'b0, 2'd0});
            #1;
            e = sb.pop_front();
            checks_total++;
            if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
            else
                checks_passed++;
            foreach (post[i]) begin
                apply(post[i]);
                sb.push_back(exp_of($sformatf("%s_post[%0d]", names[ph], i), post[i]));
                tick();
                e = sb.pop_front();
                checks_total++;
                if ({CLK_EN, ACK, CG_STATE} !== {e.en, e.ack, e.st})
                    $display("FAIL %s: got en=%b ack=%b st=%0d, required en=%b ack=%b st=%0d", e.tag, CLK_EN, ACK, CG_STATE, e.en, e.ack, e.st);
                else
                    checks_passed++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_wake();
        test_idle_timeout();
        test_rerequest();
        test_boundaries();
        test_force_on();
        test_async_reset();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_clk_gate_ctrl
